// File: rtl/uart_bus_bridge_if.sv
// UART data-register and PicoRV32-native memory signals seen by the bridge.
// master = bridge side, slave = UART/memory side.
interface uart_bus_bridge_if;
  logic [31:0] u_dat_do;
  logic        u_dat_re;
  logic        u_dat_we;
  logic [31:0] u_dat_di;
  logic        u_dat_wait;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  u_dat_do, u_dat_wait, mem_ready, mem_rdata,
    output u_dat_re, u_dat_we, u_dat_di, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output u_dat_do, u_dat_wait, mem_ready, mem_rdata,
    input  u_dat_re, u_dat_we, u_dat_di, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// UART command engine: decodes W/R byte commands from the UART RX register, masters one
// memory transaction per command and returns ACK/NAK or read data through the UART TX register.
module uart_bus_bridge #(
  parameter logic [31:0] TIMEOUT  = 32'd2000000,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15
) (
  input  logic              clk,
  input  logic              resetn,
  uart_bus_bridge_if.master bus,
  output logic              busy
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_TX} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  tx_last_q, tx_last_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tx_buf_q, tx_buf_d;
  logic        is_wr_q, is_wr_d;
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic [31:0] di_q, di_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        busy_q, busy_d;

  logic        rx_avail_c;
  logic [7:0]  rx_byte_c;
  logic [31:0] cnt_inc_c;
  logic        timeout_c;
  logic [1:0]  k_nx_c;

  // The cycle after a pop (re_q high) the RX register is still settling and is ignored.
  assign rx_avail_c = !bus.u_dat_do[31] && !re_q;
  assign rx_byte_c  = bus.u_dat_do[7:0];
  assign cnt_inc_c  = cnt_q + 32'd1;
  assign timeout_c  = (TIMEOUT != 32'd0) && (cnt_inc_c >= TIMEOUT);
  assign k_nx_c     = k_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    k_d       = k_q;
    tx_last_d = tx_last_q;
    cnt_d     = cnt_q;
    tx_buf_d  = tx_buf_q;
    is_wr_d   = is_wr_q;
    re_d      = 1'b0;
    we_d      = we_q;
    di_d      = di_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;

    case (state_q)
      S_IDLE: begin
        if (rx_avail_c) begin
          re_d = 1'b1;
          if (rx_byte_c == OP_WRITE || rx_byte_c == OP_READ) begin
            is_wr_d = (rx_byte_c == OP_WRITE);
            idx_d   = 2'd0;
            cnt_d   = 32'd0;
            state_d = S_ADDR;
          end else begin
            tx_buf_d  = {24'h0, NAK_BYTE};
            tx_last_d = 2'd0;
            k_d       = 2'd0;
            we_d      = 1'b1;
            di_d      = {24'h0, NAK_BYTE};
            state_d   = S_TX;
          end
        end
      end
      S_ADDR: begin
        if (rx_avail_c) begin
          re_d = 1'b1;
          cnt_d = 32'd0;
          addr_d[{idx_q, 3'b000} +: 8] = rx_byte_c;
          if (idx_q == 2'd0) addr_d[1:0] = 2'b00;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = S_DATA;
            end else begin
              wstrb_d = 4'b0000;
              state_d = S_BUS;
            end
          end
        end else if (timeout_c) begin
          cnt_d   = 32'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      S_DATA: begin
        if (rx_avail_c) begin
          re_d  = 1'b1;
          cnt_d = 32'd0;
          wdata_d[{idx_q, 3'b000} +: 8] = rx_byte_c;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            wstrb_d = 4'b1111;
            state_d = S_BUS;
          end
        end else if (timeout_c) begin
          cnt_d   = 32'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      S_BUS: begin
        // Request rises one cycle after entry, i.e. after the final pop has settled.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus.mem_ready) begin
          valid_d = 1'b0;
          k_d     = 2'd0;
          we_d    = 1'b1;
          state_d = S_TX;
          if (is_wr_q) begin
            tx_buf_d  = {24'h0, ACK_BYTE};
            tx_last_d = 2'd0;
            di_d      = {24'h0, ACK_BYTE};
          end else begin
            tx_buf_d  = bus.mem_rdata;
            tx_last_d = 2'd3;
            di_d      = {24'h0, bus.mem_rdata[7:0]};
          end
        end
      end
      S_TX: begin
        if (we_q && !bus.u_dat_wait) begin
          if (k_q == tx_last_q) begin
            we_d    = 1'b0;
            state_d = S_IDLE;
          end else begin
            k_d  = k_nx_c;
            di_d = {24'h0, tx_buf_q[{k_nx_c, 3'b000} +: 8]};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      k_q       <= 2'd0;
      tx_last_q <= 2'd0;
      cnt_q     <= 32'd0;
      tx_buf_q  <= 32'd0;
      is_wr_q   <= 1'b0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      di_q      <= 32'd0;
      valid_q   <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      tx_last_q <= tx_last_d;
      cnt_q     <= cnt_d;
      tx_buf_q  <= tx_buf_d;
      is_wr_q   <= is_wr_d;
      re_q      <= re_d;
      we_q      <= we_d;
      di_q      <= di_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.u_dat_re  = re_q;
  assign bus.u_dat_we  = we_q;
  assign bus.u_dat_di  = di_q;
  assign bus.mem_valid = valid_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: UART/memory models plus a command-level reference model
// predicting reply bytes and bus operations.
module tb_uart_bus_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } op_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  uart_bus_bridge_if bif ();

  uart_bus_bridge #(.TIMEOUT(32'd100), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .clk(clk), .resetn(resetn), .bus(bif.master), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  exp_tx[$];
  op_t         bus_log[$];
  op_t         exp_bus[$];
  logic [31:0] bus_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  int   lat = 0;
  int   wcnt = 0;
  logic rand_wait = 1'b0;
  logic hold_wait = 1'b0;

  int cyc = 0, last_re_cyc = 0, valid_rise_cyc = 0, done_cyc = 0, we_rise_cyc = 0;
  int re_err = 0, overlap_err = 0, stab_err = 0, tx_stab_err = 0;
  logic        prev_re = 1'b0, prev_valid = 1'b0, prev_we = 1'b0, prev_wait = 1'b0;
  logic [67:0] prev_req = '0;
  logic [31:0] prev_di = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // UART RX register: head of rx_q, popped by the read strobe
  always @(posedge clk) begin
    if (bif.u_dat_re && rx_q.size() > 0) void'(rx_q.pop_front());
    bif.u_dat_do <= (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'hFFFF_FFFF;
  end

  always @(negedge clk) bif.u_dat_wait = rand_wait ? 1'($urandom_range(0, 1)) : hold_wait;

  // Memory slave with programmable wait cycles
  always @(posedge clk) begin
    if (!resetn || !bif.mem_valid) begin
      bif.mem_ready <= 1'b0;
      wcnt <= 0;
    end else if (bif.mem_ready) begin
      bus_log.push_back('{bif.mem_addr, bif.mem_wdata, bif.mem_wstrb});
      if (bif.mem_wstrb == 4'hF) bus_mem[bif.mem_addr] = bif.mem_wdata;
      bif.mem_ready <= 1'b0;
      wcnt <= 0;
    end else if (wcnt >= lat) begin
      bif.mem_ready <= 1'b1;
      bif.mem_rdata <= bus_mem.exists(bif.mem_addr) ? bus_mem[bif.mem_addr] : dflt(bif.mem_addr);
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // Protocol monitor: TX capture, event timestamps, invariant counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resetn) begin
      if (bif.u_dat_re) last_re_cyc <= cyc;
      if (bif.u_dat_re && prev_re) re_err <= re_err + 1;
      if (bif.mem_valid && !prev_valid) valid_rise_cyc <= cyc;
      if (bif.mem_valid && bif.mem_ready) done_cyc <= cyc;
      if (bif.u_dat_we && !prev_we) we_rise_cyc <= cyc;
      if (bif.u_dat_we && bif.mem_valid) overlap_err <= overlap_err + 1;
      if (bif.mem_valid && prev_valid && {bif.mem_addr, bif.mem_wdata, bif.mem_wstrb} != prev_req)
        stab_err <= stab_err + 1;
      if (prev_we && prev_wait && (!bif.u_dat_we || bif.u_dat_di != prev_di))
        tx_stab_err <= tx_stab_err + 1;
      if (bif.u_dat_we && !bif.u_dat_wait) tx_log.push_back(bif.u_dat_di[7:0]);
    end
    prev_re    <= resetn && bif.u_dat_re;
    prev_valid <= resetn && bif.mem_valid;
    prev_we    <= resetn && bif.u_dat_we;
    prev_wait  <= bif.u_dat_wait;
    prev_req   <= {bif.mem_addr, bif.mem_wdata, bif.mem_wstrb};
    prev_di    <= bif.u_dat_di;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue the command bytes and predict the bus op and reply
  task automatic model_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wa, v;
    wa = {a[31:2], 2'b00};
    rx_q.push_back(op);
    if (op == 8'h57 || op == 8'h52) begin
      for (int i = 0; i < 4; i++) rx_q.push_back(a[8*i +: 8]);
    end
    if (op == 8'h57) begin
      for (int i = 0; i < 4; i++) rx_q.push_back(d[8*i +: 8]);
      exp_bus.push_back('{wa, d, 4'hF});
      ref_mem[wa] = d;
      exp_tx.push_back(8'h06);
    end else if (op == 8'h52) begin
      exp_bus.push_back('{wa, 32'h0, 4'h0});
      v = ref_mem.exists(wa) ? ref_mem[wa] : dflt(wa);
      for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
    end else begin
      exp_tx.push_back(8'h15);
    end
  endtask

  task automatic run_done(input int budget);
    int c = 0;
    while ((tx_log.size() < exp_tx.size() || rx_q.size() != 0 || busy !== 1'b0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("done_in_budget", 64'(c < budget), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_tx_count"}, 64'(tx_log.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      check({tag, "_tx_byte"}, 64'(tx_log[i]), 64'(exp_tx[i]));
    check({tag, "_bus_count"}, 64'(bus_log.size()), 64'(exp_bus.size()));
    for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++) begin
      check({tag, "_bus_addr"}, 64'(bus_log[i].addr), 64'(exp_bus[i].addr));
      check({tag, "_bus_wstrb"}, 64'(bus_log[i].wstrb), 64'(exp_bus[i].wstrb));
      if (exp_bus[i].wstrb == 4'hF)
        check({tag, "_bus_wdata"}, 64'(bus_log[i].wdata), 64'(exp_bus[i].wdata));
    end
    tx_log.delete();
    exp_tx.delete();
    bus_log.delete();
    exp_bus.delete();
  endtask

  initial begin
    int c;
    int bad;
    logic [31:0] di0;
    logic [7:0]  op;
    int r;

    repeat (3) @(negedge clk);
    check("rst_re",    64'(bif.u_dat_re),  64'd0);
    check("rst_we",    64'(bif.u_dat_we),  64'd0);
    check("rst_di",    64'(bif.u_dat_di),  64'd0);
    check("rst_valid", 64'(bif.mem_valid), 64'd0);
    check("rst_addr",  64'(bif.mem_addr),  64'd0);
    check("rst_wdata", 64'(bif.mem_wdata), 64'd0);
    check("rst_wstrb", 64'(bif.mem_wstrb), 64'd0);
    check("rst_busy",  64'(busy),          64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Read of a preloaded word with a 3-cycle memory wait
    bus_mem[32'h10] = 32'h11223344;
    ref_mem[32'h10] = 32'h11223344;
    lat = 3;
    model_cmd(8'h52, 32'h10, 32'h0);
    run_done(400);
    check("t2_valid_latency", 64'(valid_rise_cyc - last_re_cyc), 64'd1);
    check("t2_tx_latency",    64'(we_rise_cyc - done_cyc),       64'd1);
    compare_all("t2");

    // Write with ACK
    lat = 1;
    model_cmd(8'h57, 32'h10, 32'hDEADBEEF);
    run_done(400);
    check("t1_valid_latency", 64'(valid_rise_cyc - last_re_cyc), 64'd1);
    check("t1_tx_latency",    64'(we_rise_cyc - done_cyc),       64'd1);
    compare_all("t1");

    // Unknown opcode gets NAK with no bus cycle, then a normal write
    model_cmd(8'h41, 32'h0, 32'h0);
    run_done(200);
    compare_all("t3_nak");
    model_cmd(8'h57, 32'h27, 32'h0BADF00D);
    run_done(400);
    compare_all("t3_w");

    // Truncated write abandoned on inter-byte timeout
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h20);
    rx_q.push_back(8'h00);
    repeat (20) @(negedge clk);
    check("t4_busy_mid", 64'(busy), 64'd1);
    repeat (130) @(negedge clk);
    check("t4_busy_after", 64'(busy), 64'd0);
    compare_all("t4_abandon");
    model_cmd(8'h52, 32'h10, 32'h0);
    run_done(400);
    compare_all("t4_r");

    // TX held off by u_dat_wait for 50 cycles
    hold_wait = 1'b1;
    @(negedge clk);
    model_cmd(8'h52, 32'h24, 32'h0);
    c = 0;
    while (bif.u_dat_we !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("t5_we_seen", 64'(bif.u_dat_we), 64'd1);
    di0 = bif.u_dat_di;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bif.u_dat_we !== 1'b1 || bif.u_dat_di !== di0) bad++;
    end
    check("t5_hold_stable", 64'(bad), 64'd0);
    check("t5_no_accept", 64'(tx_log.size()), 64'd0);
    hold_wait = 1'b0;
    run_done(400);
    compare_all("t5");

    // Reset asserted while the bus request is outstanding
    lat = 1000;
    rx_q.push_back(8'h57);
    for (int i = 0; i < 8; i++) rx_q.push_back(8'(8'h30 + i));
    c = 0;
    while (bif.mem_valid !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("t6_valid_seen", 64'(bif.mem_valid), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("t6_valid_dropped", 64'(bif.mem_valid), 64'd0);
    check("t6_busy_dropped",  64'(busy),          64'd0);
    check("t6_we_low",        64'(bif.u_dat_we),  64'd0);
    resetn = 1'b1;
    lat = 2;
    repeat (3) @(negedge clk);
    compare_all("t6_abandon");
    model_cmd(8'h57, 32'h30, 32'hCAFE0001);
    model_cmd(8'h52, 32'h30, 32'h0);
    run_done(800);
    compare_all("t6_fresh");

    // Randomized batches of queued commands with random TX back-pressure
    rand_wait = 1'b1;
    for (int b = 0; b < 3; b++) begin
      lat = $urandom_range(0, 4);
      for (int n = 0; n < 8; n++) begin
        r = $urandom_range(0, 9);
        if (r < 4) op = 8'h57;
        else if (r < 8) op = 8'h52;
        else begin
          op = 8'($urandom);
          if (op == 8'h57 || op == 8'h52) op = 8'h41;
        end
        model_cmd(op, 32'h100 + 32'($urandom_range(0, 31)), $urandom);
      end
      run_done(4000);
      compare_all("rand");
    end
    rand_wait = 1'b0;
    repeat (3) @(negedge clk);

    check("inv_re_single", 64'(re_err),      64'd0);
    check("inv_we_vs_bus", 64'(overlap_err), 64'd0);
    check("inv_req_stable", 64'(stab_err),   64'd0);
    check("inv_tx_stable", 64'(tx_stab_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
